// File: rtl/uart_tx_ctrl_if.sv
// Transmit-buffer port between the UART transmitter and its byte FIFO.
// master = transmitter (pops bytes), slave = buffer (presents head byte).
interface uart_tx_ctrl_if;
  logic [7:0] buf_data;
  logic       buf_empty;
  logic       buf_rd;

  modport master (input buf_data, input buf_empty, output buf_rd);
  modport slave  (output buf_data, output buf_empty, input buf_rd);
endinterface

// File: rtl/uart_tx_ctrl.sv
// 8N1 UART transmitter: pops one byte from the transmit buffer per frame
// and serializes it LSB first. Every output is registered.
module uart_tx_ctrl #(
  parameter int unsigned CLKS_PER_BIT = 434
) (
  input  logic          CLK,
  input  logic          rst,
  input  logic          enable,
  uart_tx_ctrl_if.master bif,
  output logic          tx,
  output logic          busy,
  output logic          frame_done
);

  localparam int unsigned BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

  typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_e;

  state_e        state_q, state_d;
  logic [BW-1:0] baud_q, baud_d;
  logic [2:0]    bit_q, bit_d;
  logic [7:0]    sh_q, sh_d;
  logic          tx_q, tx_d;
  logic          busy_q, busy_d;
  logic          rd_q, rd_d;
  logic          fd_q, fd_d;
  logic          bit_end;

  assign bit_end = (baud_q == BAUD_LAST);

  always_comb begin
    state_d = state_q;
    baud_d  = baud_q;
    bit_d   = bit_q;
    sh_d    = sh_q;
    rd_d    = 1'b0;
    case (state_q)
      IDLE: begin
        if (enable && !bif.buf_empty) begin
          sh_d    = bif.buf_data;
          rd_d    = 1'b1;
          baud_d  = '0;
          bit_d   = '0;
          state_d = START;
        end
      end
      START: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = DATA;
        end else baud_d = baud_q + 1'b1;
      end
      DATA: begin
        if (bit_end) begin
          baud_d = '0;
          sh_d   = {1'b0, sh_q[7:1]};
          bit_d  = bit_q + 3'd1;
          if (bit_q == 3'd7) state_d = STOP;
        end else baud_d = baud_q + 1'b1;
      end
      STOP: begin
        if (bit_end) begin
          baud_d  = '0;
          state_d = IDLE;
        end else baud_d = baud_q + 1'b1;
      end
      default: state_d = IDLE;
    endcase

    // Outputs are derived from next-state values so the registers line up
    // with the state they describe.
    tx_d   = (state_d == START) ? 1'b0 : (state_d == DATA) ? sh_d[0] : 1'b1;
    busy_d = (state_d != IDLE);
    fd_d   = (state_d == STOP) && (baud_d == BAUD_LAST);
  end

  always_ff @(posedge CLK) begin
    if (rst) begin
      state_q <= IDLE;
      baud_q  <= '0;
      bit_q   <= '0;
      sh_q    <= '0;
      tx_q    <= 1'b1;
      busy_q  <= 1'b0;
      rd_q    <= 1'b0;
      fd_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      baud_q  <= baud_d;
      bit_q   <= bit_d;
      sh_q    <= sh_d;
      tx_q    <= tx_d;
      busy_q  <= busy_d;
      rd_q    <= rd_d;
      fd_q    <= fd_d;
    end
  end

  assign tx         = tx_q;
  assign busy       = busy_q;
  assign frame_done = fd_q;
  assign bif.buf_rd = rd_q;

endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Directed bench for uart_tx_ctrl at CLKS_PER_BIT=4; traces outputs per cycle
// into bit vectors and compares them with hand-built frame expectations.
module tb_uart_tx_ctrl;
  logic CLK = 1'b0;
  logic rst, enable, tx, busy, frame_done;
  uart_tx_ctrl_if bif ();

  uart_tx_ctrl #(.CLKS_PER_BIT(4)) dut (
    .CLK(CLK), .rst(rst), .enable(enable), .bif(bif),
    .tx(tx), .busy(busy), .frame_done(frame_done)
  );

  always #5 CLK = ~CLK;

  int errors = 0;
  int checks = 0;
  int rd_empty = 0;
  logic [7:0] bq[$];
  logic [127:0] tx_tr, busy_tr, fd_tr, rd_tr;
  logic [127:0] exp_tx, exp_busy, exp_fd, exp_rd;

  task automatic drive_buf();
    bif.buf_empty = (bq.size() == 0);
    bif.buf_data  = (bq.size() != 0) ? bq[0] : 8'h00;
  endtask

  task automatic push(input logic [7:0] b);
    bq.push_back(b);
    drive_buf();
  endtask

  task automatic clear_all();
    tx_tr = '1; busy_tr = '0; fd_tr = '0; rd_tr = '0;
    exp_tx = '1; exp_busy = '0; exp_fd = '0; exp_rd = '0;
  endtask

  // One cycle: sample outputs at the falling edge; a visible buf_rd means the
  // buffer pops on the coming rising edge.
  task automatic run(input int start, input int n);
    for (int i = start; i < start + n; i++) begin
      @(negedge CLK);
      if (i < 128) begin
        tx_tr[i] = tx; busy_tr[i] = busy; fd_tr[i] = frame_done; rd_tr[i] = bif.buf_rd;
      end
      if (bif.buf_rd) begin
        if (bq.size() == 0) rd_empty++;
        else void'(bq.pop_front());
      end
      drive_buf();
    end
  endtask

  // Expected frame of byte b starting at cycle off, first len cycles of it.
  task automatic add_frame(input logic [7:0] b, input int off, input int len);
    for (int i = 0; i < len; i++) begin
      exp_tx[off+i]   = (i < 4) ? 1'b0 : (i < 36) ? b[(i-4)/4] : 1'b1;
      exp_busy[off+i] = 1'b1;
      if (i == 39) exp_fd[off+i] = 1'b1;
    end
    if (len > 0) exp_rd[off] = 1'b1;
  endtask

  task automatic test_reset();
    rst = 1'b1; enable = 1'b0; drive_buf();
    clear_all();
    run(0, 3);
    checks++; if (tx_tr[2] !== 1'b1) begin errors++; $display("FAIL reset_tx got=%b exp=1", tx_tr[2]); end
    checks++; if (busy_tr[2] !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", busy_tr[2]); end
    checks++; if (rd_tr[2] !== 1'b0) begin errors++; $display("FAIL reset_rd got=%b exp=0", rd_tr[2]); end
    checks++; if (fd_tr[2] !== 1'b0) begin errors++; $display("FAIL reset_fd got=%b exp=0", fd_tr[2]); end
    rst = 1'b0;
    run(0, 2);
  endtask

  task automatic test_single();
    clear_all();
    push(8'h55); enable = 1'b1;
    run(0, 48);
    add_frame(8'h55, 0, 40);
    checks++; if (tx_tr !== exp_tx) begin errors++; $display("FAIL single_tx got=%h exp=%h", tx_tr, exp_tx); end
    checks++; if (busy_tr !== exp_busy) begin errors++; $display("FAIL single_busy got=%h exp=%h", busy_tr, exp_busy); end
    checks++; if (fd_tr !== exp_fd) begin errors++; $display("FAIL single_fd got=%h exp=%h", fd_tr, exp_fd); end
    checks++; if (rd_tr !== exp_rd) begin errors++; $display("FAIL single_rd got=%h exp=%h", rd_tr, exp_rd); end
    checks++; if (bq.size() !== 0) begin errors++; $display("FAIL single_pop got=%0d exp=0", bq.size()); end
    enable = 1'b0;
  endtask

  task automatic test_back_to_back();
    clear_all();
    push(8'hA3); push(8'h0F); enable = 1'b1;
    run(0, 90);
    add_frame(8'hA3, 0, 40);
    add_frame(8'h0F, 41, 40);
    checks++; if (tx_tr !== exp_tx) begin errors++; $display("FAIL b2b_tx got=%h exp=%h", tx_tr, exp_tx); end
    checks++; if (busy_tr !== exp_busy) begin errors++; $display("FAIL b2b_busy got=%h exp=%h", busy_tr, exp_busy); end
    checks++; if (fd_tr !== exp_fd) begin errors++; $display("FAIL b2b_fd got=%h exp=%h", fd_tr, exp_fd); end
    checks++; if (rd_tr !== exp_rd) begin errors++; $display("FAIL b2b_rd got=%h exp=%h", rd_tr, exp_rd); end
    enable = 1'b0;
  endtask

  task automatic test_empty_disabled();
    clear_all();
    enable = 1'b1;
    run(0, 100);
    checks++; if (tx_tr !== exp_tx) begin errors++; $display("FAIL empty_tx got=%h exp=%h", tx_tr, exp_tx); end
    checks++; if (busy_tr !== exp_busy) begin errors++; $display("FAIL empty_busy got=%h exp=%h", busy_tr, exp_busy); end
    checks++; if (rd_tr !== exp_rd) begin errors++; $display("FAIL empty_rd got=%h exp=%h", rd_tr, exp_rd); end
    clear_all();
    enable = 1'b0; push(8'h3C);
    run(0, 100);
    checks++; if (tx_tr !== exp_tx) begin errors++; $display("FAIL disabled_tx got=%h exp=%h", tx_tr, exp_tx); end
    checks++; if (busy_tr !== exp_busy) begin errors++; $display("FAIL disabled_busy got=%h exp=%h", busy_tr, exp_busy); end
    checks++; if (rd_tr !== exp_rd) begin errors++; $display("FAIL disabled_rd got=%h exp=%h", rd_tr, exp_rd); end
    checks++; if (bq.size() !== 1) begin errors++; $display("FAIL disabled_depth got=%0d exp=1", bq.size()); end
    bq.delete(); drive_buf();
  endtask

  task automatic test_enable_drop();
    clear_all();
    push(8'hC6); enable = 1'b1;
    run(0, 17);
    // Mid DATA bit 3: drop enable and present a new head byte.
    enable = 1'b0; push(8'h99);
    run(17, 83);
    add_frame(8'hC6, 0, 40);
    checks++; if (tx_tr !== exp_tx) begin errors++; $display("FAIL drop_tx got=%h exp=%h", tx_tr, exp_tx); end
    checks++; if (busy_tr !== exp_busy) begin errors++; $display("FAIL drop_busy got=%h exp=%h", busy_tr, exp_busy); end
    checks++; if (fd_tr !== exp_fd) begin errors++; $display("FAIL drop_fd got=%h exp=%h", fd_tr, exp_fd); end
    checks++; if (rd_tr !== exp_rd) begin errors++; $display("FAIL drop_rd got=%h exp=%h", rd_tr, exp_rd); end
    checks++; if (bq.size() !== 1) begin errors++; $display("FAIL drop_depth got=%0d exp=1", bq.size()); end
    bq.delete(); drive_buf();
  endtask

  task automatic test_reset_mid_frame();
    clear_all();
    push(8'hFF); enable = 1'b1;
    run(0, 20);
    rst = 1'b1; enable = 1'b0;
    run(20, 1);
    rst = 1'b0; push(8'h12);
    run(21, 9);
    enable = 1'b1;
    run(30, 50);
    add_frame(8'hFF, 0, 20);
    add_frame(8'h12, 30, 40);
    checks++; if (tx_tr !== exp_tx) begin errors++; $display("FAIL rstmid_tx got=%h exp=%h", tx_tr, exp_tx); end
    checks++; if (busy_tr !== exp_busy) begin errors++; $display("FAIL rstmid_busy got=%h exp=%h", busy_tr, exp_busy); end
    checks++; if (fd_tr !== exp_fd) begin errors++; $display("FAIL rstmid_fd got=%h exp=%h", fd_tr, exp_fd); end
    checks++; if (rd_tr !== exp_rd) begin errors++; $display("FAIL rstmid_rd got=%h exp=%h", rd_tr, exp_rd); end
    enable = 1'b0;
  endtask

  initial begin
    test_reset();
    test_single();
    test_back_to_back();
    test_empty_disabled();
    test_enable_drop();
    test_reset_mid_frame();
    checks++; if (rd_empty !== 0) begin errors++; $display("FAIL rd_while_empty got=%0d exp=0", rd_empty); end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule

// File: doc/uart_tx_ctrl.md
UART_TX_CTRL -- requirements
Module: uart_tx_ctrl

Interface
REQ-001 Parameter CLKS_PER_BIT, default 434, CLK cycles per UART bit period (50 MHz / 115200 baud); legal range 2..65535.
REQ-002 CLK  input  1  sole clock; all state updates on rising edge.
REQ-003 rst  input  1  reset; one clock; reset is synchronous and active-high.
REQ-004 enable  input  1  permits new frames to start; sampled only in IDLE.
REQ-005 buf_data  input  8  head byte of the transmit buffer, valid whenever buf_empty=0.
REQ-006 buf_empty  input  1  transmit buffer holds no bytes.
REQ-007 buf_rd  output  1  single-cycle pop strobe to the transmit buffer.
REQ-008 tx  output  1  serial line; idle/mark level high.
REQ-009 busy  output  1  high while a frame is in progress (any state other than IDLE).
REQ-010 frame_done  output  1  single-cycle pulse marking the end of a frame's stop bit.

Function
REQ-011 The block SHALL implement states IDLE, START, DATA and STOP, with all outputs registered.
REQ-012 In IDLE, if enable=1 and buf_empty=0, the block SHALL:
- latch buf_data into an 8-bit shift register;
- assert buf_rd for exactly that one cycle;
- enter START with the bit counter and baud counter cleared.
REQ-013 buf_rd SHALL never be asserted outside the IDLE->START transition, and SHALL never be asserted while buf_empty=1.
REQ-014 START SHALL drive tx=0 for exactly CLKS_PER_BIT cycles, then enter DATA.
REQ-015 DATA SHALL transmit 8 bits LSB first, each held for exactly CLKS_PER_BIT cycles; the shift register shifts right once per bit period.
REQ-016 A 3-bit bit index SHALL count 0..7; after bit 7's period, the block SHALL enter STOP.
REQ-017 STOP SHALL drive tx=1 for exactly CLKS_PER_BIT cycles.
REQ-018 On the last cycle of STOP, frame_done SHALL be asserted for one cycle; the block then returns to IDLE.
REQ-019 The baud counter SHALL count 0..CLKS_PER_BIT-1 and wrap to 0 at every bit boundary; its width is ceil(log2(CLKS_PER_BIT)).
REQ-020 Each frame SHALL last exactly 10*CLKS_PER_BIT cycles measured from the first tx=0 cycle to the last stop-bit cycle.
REQ-021 The block SHALL spend at least one cycle in IDLE between frames; back-to-back frames are separated by exactly one IDLE cycle of tx=1.
REQ-022 Deasserting enable mid-frame SHALL NOT affect the current frame; no new frame starts while enable=0.
REQ-023 Changes to buf_data or buf_empty during START/DATA/STOP SHALL NOT affect the frame in flight.
REQ-024 When buf_empty=1 in IDLE, the block SHALL remain in IDLE with tx=1, busy=0 and buf_rd=0, regardless of enable.
REQ-025 busy SHALL be asserted from the first START cycle through the last STOP cycle inclusive.

Reset
REQ-026 While rst=1 at a rising edge, the block SHALL enter IDLE with:
- tx=1, busy=0, buf_rd=0, frame_done=0;
- shift register, bit index and baud counter = 0.
REQ-027 Reset asserted mid-frame SHALL abort the frame: tx=1 from the next cycle, no frame_done, no additional buf_rd.
REQ-028 After rst deasserts, the first frame MAY start on the first IDLE cycle that meets REQ-012.

Verification (CLKS_PER_BIT=4)
REQ-029 Single byte: buffer holds 0x55, enable=1 ->
- one buf_rd pulse;
- tx = 0 for 4 cycles, then 1,0,1,0,1,0,1,0 each for 4 cycles, then 1 for 4 cycles;
- frame_done on cycle 40; busy for 40 cycles.
REQ-030 Back-to-back: buffer holds 0xA3 then 0x0F ->
- two frames separated by exactly one tx=1 IDLE cycle;
- exactly two buf_rd pulses;
- serialized bits match LSB-first encoding of each byte.
REQ-031 Empty/disabled:
- buf_empty=1, enable=1 for 100 cycles -> tx=1, buf_rd=0, busy=0 throughout;
- buf_empty=0, enable=0 -> same result.
REQ-032 Enable drop: enable deasserted during DATA bit 3 of 0xC6 -> frame completes intact, frame_done pulses, no further buf_rd while enable=0.
REQ-033 Reset mid-frame: rst asserted for 1 cycle during DATA of 0xFF ->
- tx=1, busy=0 the next cycle;
- no frame_done;
- next frame starts cleanly with buffer head byte 0x12 once enable=1.
